// File: rtl/bitty_uart_pkg.sv
// Shared definitions for the bitty UART memory responder: command codes,
// frame lengths and the responder state encoding.
package bitty_uart_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_STORE = 8'h02;

  localparam int LOAD_FRAME_BYTES  = 2;
  localparam int STORE_FRAME_BYTES = 4;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DLO,
    GET_DHI,
    WRITE,
    SEND_LO,
    WAIT_LO,
    SEND_HI,
    WAIT_HI
  } resp_state_t;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } resp_op_t;

  function automatic logic is_valid_cmd(input logic [7:0] b);
    return (b == CMD_LOAD) || (b == CMD_STORE);
  endfunction

endpackage

// File: rtl/bitty_word_ram.sv
// DEPTH x 16 word memory: one synchronous write port and two asynchronous
// read ports (one for the responder FSM, one for debug observation).
module bitty_word_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o,
  input  logic [AW-1:0] dbg_raddr_i,
  output logic [15:0]   dbg_rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose; contents survive reset
  // and a reset term would force a flop-per-bit implementation.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o     = mem_q[raddr_i];
  assign dbg_rdata_o = mem_q[dbg_raddr_i];

endmodule

// File: rtl/bitty_uart_mem_responder.sv
// Serial-link responder: parses LOAD/STORE frames arriving as UART bytes,
// services them against a local word memory and returns load data as two bytes.
module bitty_uart_mem_responder
  import bitty_uart_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              cmd_err,
  output logic              ovr_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [15:0]       dbg_data
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  resp_state_t       state_q;
  resp_op_t          op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dlo_q;
  logic [7:0]        dhi_q;
  logic              tx_en_q;
  logic [7:0]        tx_data_q;
  logic              cmd_err_q;
  logic              ovr_err_q;

  logic        addr_in_range;
  logic        dbg_in_range;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] ram_dbg_rdata;
  logic [15:0] rd_word;
  logic        in_tx_phase;

  assign addr_in_range = {1'b0, addr_q}   < DEPTH_L;
  assign dbg_in_range  = {1'b0, dbg_addr} < DEPTH_L;
  assign ram_we        = (state_q == WRITE) && addr_in_range;
  assign rd_word       = addr_in_range ? ram_rdata : 16'h0000;
  assign in_tx_phase   = (state_q == SEND_LO) || (state_q == WAIT_LO) ||
                         (state_q == SEND_HI) || (state_q == WAIT_HI);

  bitty_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk         (clk),
    .we_i        (ram_we),
    .waddr_i     (addr_q[AW-1:0]),
    .wdata_i     ({dhi_q, dlo_q}),
    .raddr_i     (addr_q[AW-1:0]),
    .rdata_o     (ram_rdata),
    .dbg_raddr_i (dbg_addr[AW-1:0]),
    .dbg_rdata_o (ram_dbg_rdata)
  );

  // NOTE: strobes default low at the top of the clocked block, so each branch
  // only states when a pulse fires; later non-blocking writes win.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      addr_q    <= '0;
      dlo_q     <= '0;
      dhi_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      cmd_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      tx_en_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      ovr_err_q <= rx_done && in_tx_phase;

      case (state_q)
        IDLE: begin
          if (rx_done) begin
            if (is_valid_cmd(rx_data)) begin
              op_q    <= (rx_data == CMD_LOAD) ? OP_LOAD : OP_STORE;
              state_q <= GET_ADDR;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        GET_ADDR: begin
          if (rx_done) begin
            addr_q  <= rx_data[ADDR_W-1:0];
            state_q <= (op_q == OP_LOAD) ? SEND_LO : GET_DLO;
          end
        end
        GET_DLO: begin
          if (rx_done) begin
            dlo_q   <= rx_data;
            state_q <= GET_DHI;
          end
        end
        GET_DHI: begin
          if (rx_done) begin
            dhi_q   <= rx_data;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          cmd_err_q <= !addr_in_range;
          state_q   <= IDLE;
        end
        SEND_LO: begin
          // Out-of-range loads still answer with two zero bytes so the LSU never stalls.
          tx_data_q <= rd_word[7:0];
          tx_en_q   <= 1'b1;
          cmd_err_q <= !addr_in_range;
          state_q   <= WAIT_LO;
        end
        WAIT_LO: begin
          if (tx_done) begin
            state_q <= SEND_HI;
          end
        end
        SEND_HI: begin
          tx_data_q <= rd_word[15:8];
          tx_en_q   <= 1'b1;
          state_q   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign cmd_err  = cmd_err_q;
  assign ovr_err  = ovr_err_q;
  assign dbg_data = dbg_in_range ? ram_dbg_rdata : 16'h0000;

endmodule

// File: tb/tb_bitty_uart_mem_responder.sv
// Self-checking bench for bitty_uart_mem_responder: frame-level memory model,
// a UART-transmitter stand-in that checks every response byte, and directed tests.
module tb_bitty_uart_mem_responder;
  import bitty_uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int TX_DLY = 6;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        cmd_err;
  logic        ovr_err;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_data;

  bitty_uart_mem_responder #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_done  (tx_done),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .ovr_err  (ovr_err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [DEPTH];
  logic [7:0]  frame_q [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  tx_log [$];
  int          exp_cmd_err = 0;
  int          exp_ovr_err = 0;
  int          obs_cmd_err = 0;
  int          obs_ovr_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a);
    return (int'(a) < DEPTH) ? model_mem[a[3:0]] : 16'h0000;
  endfunction

  // Frame-level model: a whole frame's effect is applied once its last byte is sent.
  task automatic feed_model(input logic [7:0] b);
    int          len;
    logic [7:0]  a;
    logic [15:0] w;
    if (frame_q.size() == 0 && !(b == CMD_LOAD || b == CMD_STORE)) begin
      exp_cmd_err++;
      return;
    end
    frame_q.push_back(b);
    len = (frame_q[0] == CMD_LOAD) ? LOAD_FRAME_BYTES : STORE_FRAME_BYTES;
    if (frame_q.size() == len) begin
      a = frame_q[1];
      if (frame_q[0] == CMD_LOAD) begin
        if (int'(a) >= DEPTH) exp_cmd_err++;
        w = model_read(a);
        exp_tx.push_back(w[7:0]);
        exp_tx.push_back(w[15:8]);
      end else if (int'(a) < DEPTH) begin
        model_mem[a[3:0]] = {frame_q[3], frame_q[2]};
      end else begin
        exp_cmd_err++;
      end
      frame_q.delete();
    end
  endtask

  task automatic send_raw(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    feed_model(b);
    send_raw(b);
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] w);
    send_byte(CMD_STORE);
    send_byte(a);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && !tx_done) done = 1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep_dbg();
    logic [7:0] a;
    for (int i = 0; i < DEPTH + 4; i++) begin
      a = (i < DEPTH + 2) ? 8'(i) : ((i == DEPTH + 2) ? 8'h20 : 8'hFF);
      dbg_addr = a;
      #1;
      check($sformatf("dbg_data[%0h]", a), dbg_data, model_read(a));
    end
  endtask

  // UART transmitter stand-in: checks each byte, holds it, then acknowledges.
  initial begin
    logic [7:0] held;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && tx_en) begin
        held = tx_data;
        tx_log.push_back(held);
        if (exp_tx.size() == 0) begin
          check("unexpected_tx_en", 32'd1, 32'd0);
        end else begin
          check("tx_byte", tx_data, exp_tx.pop_front());
        end
        repeat (TX_DLY) begin
          @(negedge clk);
          check("tx_en_single", tx_en, 1'b0);
          check("tx_data_hold", tx_data, held);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_err) obs_cmd_err++;
      if (ovr_err) obs_ovr_err++;
    end
  end

  initial begin
    int c0;
    int o0;
    reset    = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    dbg_addr = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_ovr_err", ovr_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill memory with {i^0x5A, i} so every later load has a known value.
    for (int i = 0; i < DEPTH; i++) store(8'(i), {8'(i) ^ 8'h5A, 8'(i)});
    wait_idle();
    sweep_dbg();

    // Store/load round trip with exact write and response latency.
    dbg_addr = 8'h05;
    send_byte(CMD_STORE);
    send_byte(8'h05);
    send_byte(8'h34);
    send_byte(8'h12);
    @(negedge clk);
    check("write_not_yet", dbg_data, 16'h5F05);
    @(negedge clk);
    check("write_landed", dbg_data, 16'h1234);
    tx_log.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h05);
    @(negedge clk);
    check("dlo_latency_early", tx_en, 1'b0);
    @(negedge clk);
    check("dlo_latency", tx_en, 1'b1);
    check("dlo_value", tx_data, 8'h34);
    wait_idle();
    check("t1_log_len", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("t1_lo", tx_log[0], 8'h34);
      check("t1_hi", tx_log[1], 8'h12);
    end

    // Invalid command byte, then a normal load.
    c0 = obs_cmd_err;
    send_byte(8'h7F);
    @(negedge clk);
    check("badcmd_busy", busy, 1'b0);
    @(negedge clk);
    check("badcmd_err", obs_cmd_err - c0, 1);
    tx_log.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h00);
    wait_idle();
    check("t2_log_len", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("t2_lo", tx_log[0], 8'h00);
      check("t2_hi", tx_log[1], 8'h5A);
    end

    // Out-of-range store and load.
    c0 = obs_cmd_err;
    tx_log.delete();
    store(8'h20, 16'hBBAA);
    send_byte(CMD_LOAD);
    send_byte(8'h20);
    wait_idle();
    check("oor_cmd_err", obs_cmd_err - c0, 2);
    check("t3_log_len", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("t3_lo", tx_log[0], 8'h00);
      check("t3_hi", tx_log[1], 8'h00);
    end

    // Byte arriving while the response is in flight.
    o0 = obs_ovr_err;
    tx_log.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h07);
    repeat (3) @(posedge clk);
    send_raw(CMD_STORE);
    exp_ovr_err++;
    @(negedge clk);
    check("ovr_busy", busy, 1'b1);
    wait_idle();
    check("ovr_pulse", obs_ovr_err - o0, 1);
    check("t4_log_len", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("t4_lo", tx_log[0], 8'h07);
      check("t4_hi", tx_log[1], 8'h5D);
    end

    // Reset mid-store: the partial frame must not be written.
    send_raw(CMD_STORE);
    send_raw(8'h03);
    send_raw(8'hCD);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dbg_addr = 8'h03;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_tx_en", tx_en, 1'b0);
    check("rst_mid_mem", dbg_data, 16'h5903);
    tx_log.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h03);
    wait_idle();
    check("t5_log_len", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("t5_lo", tx_log[0], 8'h03);
      check("t5_hi", tx_log[1], 8'h59);
    end

    // Back-to-back stores with rx_done every two cycles, then loads.
    o0 = obs_ovr_err;
    for (int i = 0; i < 4; i++) store(8'(8 + i), 16'hC0DE + 16'(i * 16'h1111));
    for (int i = 0; i < 4; i++) begin
      send_byte(CMD_LOAD);
      send_byte(8'(8 + i));
      wait_idle();
    end
    check("b2b_no_ovr", obs_ovr_err - o0, 0);

    wait_idle();
    check("exp_tx_drained", exp_tx.size(), 0);
    check("cmd_err_total", obs_cmd_err, exp_cmd_err);
    check("ovr_err_total", obs_ovr_err, exp_ovr_err);
    sweep_dbg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
